// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage pipeline.
//
// Resolves RS/RT forwarding from the MEM and WB stages and computes the
// single-cycle ALU operations (AND, OR, ADD, SUB, signed SLT). MUL runs on
// an iterative shift-add multiplier that takes WIDTH steps, and stall_o
// holds the upstream pipeline registers while it runs. The result, the
// forwarded RT value and the control bits land in the EX/MEM register.
//
// Ports:
//   clk_i, rst_i            clock and synchronous active-high reset
//   valid_i                 ID/EX holds a real instruction (0 = bubble)
//   ALUCtrl_i, ALUSrc_i,    operation select, operand-B source,
//   RegDst_i                destination select
//   MemtoReg_i, RegWrite_i, control bits passed through to EX/MEM
//   MemRead_i, MemWrite_i
//   RS_i, RT_i, SignExtend_i   register operands and immediate
//   RSAddr_i, RTAddr_i, RDAddr_i   register addresses
//   MEM_* / WB_*            forwarding sources from the MEM and WB stages
//   stall_o                 combinational hold request for IF/ID and ID/EX
//   valid_o, ALUResult_o, StoreData_o, WBAddr_o,
//   MemtoReg_o, RegWrite_o, MemRead_o, MemWrite_o   EX/MEM register

module ex_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic             ALUSrc_i,
  input  logic             RegDst_i,
  input  logic             MemtoReg_i,
  input  logic             RegWrite_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic [WIDTH-1:0] RS_i,
  input  logic [WIDTH-1:0] RT_i,
  input  logic [WIDTH-1:0] SignExtend_i,
  input  logic [4:0]       RSAddr_i,
  input  logic [4:0]       RTAddr_i,
  input  logic [4:0]       RDAddr_i,
  input  logic             MEM_RegWrite_i,
  input  logic [4:0]       MEM_RDAddr_i,
  input  logic [WIDTH-1:0] MEM_Data_i,
  input  logic             WB_RegWrite_i,
  input  logic [4:0]       WB_RDAddr_i,
  input  logic [WIDTH-1:0] WB_Data_i,
  output logic             stall_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] ALUResult_o,
  output logic [WIDTH-1:0] StoreData_o,
  output logic [4:0]       WBAddr_o,
  output logic             MemtoReg_o,
  output logic             RegWrite_o,
  output logic             MemRead_o,
  output logic             MemWrite_o
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // One extra bit so the counter can represent WIDTH-1 for any WIDTH.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  state_t           next_state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_step;

  logic [WIDTH-1:0] rs_fwd;
  logic [WIDTH-1:0] rt_fwd;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_result;
  logic [4:0]       dest_addr;

  logic             launch;
  logic             last_step;

  // Control and store data of the multiply in flight, captured at launch
  logic [WIDTH-1:0] mul_store;
  logic [4:0]       mul_wb_addr;
  logic             mul_mem_to_reg;
  logic             mul_reg_write;
  logic             mul_mem_read;
  logic             mul_mem_write;

  // Forwarding: MEM beats WB, and register 0 is never forwarded.
  always_comb begin
    rs_fwd = RS_i;
    if (MEM_RegWrite_i && (MEM_RDAddr_i != 5'd0) && (MEM_RDAddr_i == RSAddr_i))
      rs_fwd = MEM_Data_i;
    else if (WB_RegWrite_i && (WB_RDAddr_i != 5'd0) && (WB_RDAddr_i == RSAddr_i))
      rs_fwd = WB_Data_i;

    rt_fwd = RT_i;
    if (MEM_RegWrite_i && (MEM_RDAddr_i != 5'd0) && (MEM_RDAddr_i == RTAddr_i))
      rt_fwd = MEM_Data_i;
    else if (WB_RegWrite_i && (WB_RDAddr_i != 5'd0) && (WB_RDAddr_i == RTAddr_i))
      rt_fwd = WB_Data_i;
  end

  assign op_a      = rs_fwd;
  assign op_b      = ALUSrc_i ? SignExtend_i : rt_fwd;
  assign dest_addr = RegDst_i ? RDAddr_i : RTAddr_i;

  // Single-cycle ALU; MUL is handled by the iterative unit instead.
  always_comb begin
    alu_result = '0;
    case (ALUCtrl_i)
      OP_AND:  alu_result = op_a & op_b;
      OP_OR:   alu_result = op_a | op_b;
      OP_ADD:  alu_result = op_a + op_b;
      OP_SUB:  alu_result = op_a - op_b;
      OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: alu_result = '0;
    endcase
  end

  assign launch    = (state == IDLE) && valid_i && (ALUCtrl_i == OP_MUL);
  assign last_step = (state == BUSY) && (count == LAST_COUNT);
  assign acc_step  = mplier[0] ? (acc + mcand) : acc;

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i)
      state <= IDLE;
    else
      state <= next_state;
  end

  // FSM next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (launch) next_state = BUSY;
      BUSY:    if (last_step) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs: the launch cycle plus every BUSY cycle except the last
  // stall, giving exactly WIDTH stalled cycles per multiply.
  always_comb begin
    stall_o = 1'b0;
    case (state)
      IDLE:    stall_o = launch;
      BUSY:    stall_o = !last_step;
      default: stall_o = 1'b0;
    endcase
  end

  // Shift-add multiplier datapath and launch-time capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count          <= '0;
      mcand          <= '0;
      mplier         <= '0;
      acc            <= '0;
      mul_store      <= '0;
      mul_wb_addr    <= '0;
      mul_mem_to_reg <= 1'b0;
      mul_reg_write  <= 1'b0;
      mul_mem_read   <= 1'b0;
      mul_mem_write  <= 1'b0;
    end else if (launch) begin
      count          <= '0;
      mcand          <= op_a;
      mplier         <= op_b;
      acc            <= '0;
      mul_store      <= rt_fwd;
      mul_wb_addr    <= dest_addr;
      mul_mem_to_reg <= MemtoReg_i;
      mul_reg_write  <= RegWrite_i;
      mul_mem_read   <= MemRead_i;
      mul_mem_write  <= MemWrite_i;
    end else if (state == BUSY) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
    end
  end

  // EX/MEM register. A bubble clears valid and control but leaves the
  // data fields holding their previous values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o     <= 1'b0;
      ALUResult_o <= '0;
      StoreData_o <= '0;
      WBAddr_o    <= '0;
      MemtoReg_o  <= 1'b0;
      RegWrite_o  <= 1'b0;
      MemRead_o   <= 1'b0;
      MemWrite_o  <= 1'b0;
    end else if (last_step) begin
      valid_o     <= 1'b1;
      ALUResult_o <= acc_step;
      StoreData_o <= mul_store;
      WBAddr_o    <= mul_wb_addr;
      MemtoReg_o  <= mul_mem_to_reg;
      RegWrite_o  <= mul_reg_write;
      MemRead_o   <= mul_mem_read;
      MemWrite_o  <= mul_mem_write;
    end else if ((state == IDLE) && valid_i && !launch) begin
      valid_o     <= 1'b1;
      ALUResult_o <= alu_result;
      StoreData_o <= rt_fwd;
      WBAddr_o    <= dest_addr;
      MemtoReg_o  <= MemtoReg_i;
      RegWrite_o  <= RegWrite_i;
      MemRead_o   <= MemRead_i;
      MemWrite_o  <= MemWrite_i;
    end else begin
      valid_o     <= 1'b0;
      MemtoReg_o  <= 1'b0;
      RegWrite_o  <= 1'b0;
      MemRead_o   <= 1'b0;
      MemWrite_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: self-checking bench for ex_stage.
//
// Directed steps followed by random instructions. Expected EX/MEM contents
// come from a behavioural model: forwarding rules, plain arithmetic for the
// ALU (including a*b for MUL) and a count of the stall cycles a MUL needs.

module tb_ex_stage;

  localparam int WIDTH = 32;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             valid_i;
  logic [2:0]       ALUCtrl_i;
  logic             ALUSrc_i;
  logic             RegDst_i;
  logic             MemtoReg_i;
  logic             RegWrite_i;
  logic             MemRead_i;
  logic             MemWrite_i;
  logic [WIDTH-1:0] RS_i;
  logic [WIDTH-1:0] RT_i;
  logic [WIDTH-1:0] SignExtend_i;
  logic [4:0]       RSAddr_i;
  logic [4:0]       RTAddr_i;
  logic [4:0]       RDAddr_i;
  logic             MEM_RegWrite_i;
  logic [4:0]       MEM_RDAddr_i;
  logic [WIDTH-1:0] MEM_Data_i;
  logic             WB_RegWrite_i;
  logic [4:0]       WB_RDAddr_i;
  logic [WIDTH-1:0] WB_Data_i;
  logic             stall_o;
  logic             valid_o;
  logic [WIDTH-1:0] ALUResult_o;
  logic [WIDTH-1:0] StoreData_o;
  logic [4:0]       WBAddr_o;
  logic             MemtoReg_o;
  logic             RegWrite_o;
  logic             MemRead_o;
  logic             MemWrite_o;

  int checks   = 0;
  int failures = 0;

  // Expected EX/MEM contents
  logic             exp_valid;
  logic [WIDTH-1:0] exp_result;
  logic [WIDTH-1:0] exp_store;
  logic [4:0]       exp_wb;
  logic [3:0]       exp_ctrl;

  ex_stage #(.WIDTH(WIDTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
    .ALUCtrl_i(ALUCtrl_i), .ALUSrc_i(ALUSrc_i), .RegDst_i(RegDst_i),
    .MemtoReg_i(MemtoReg_i), .RegWrite_i(RegWrite_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .RS_i(RS_i), .RT_i(RT_i), .SignExtend_i(SignExtend_i),
    .RSAddr_i(RSAddr_i), .RTAddr_i(RTAddr_i), .RDAddr_i(RDAddr_i),
    .MEM_RegWrite_i(MEM_RegWrite_i), .MEM_RDAddr_i(MEM_RDAddr_i),
    .MEM_Data_i(MEM_Data_i),
    .WB_RegWrite_i(WB_RegWrite_i), .WB_RDAddr_i(WB_RDAddr_i),
    .WB_Data_i(WB_Data_i),
    .stall_o(stall_o), .valid_o(valid_o), .ALUResult_o(ALUResult_o),
    .StoreData_o(StoreData_o), .WBAddr_o(WBAddr_o),
    .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o),
    .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o)
  );

  always #5 clk_i = ~clk_i;

  // Value an operand sees after forwarding
  function automatic logic [WIDTH-1:0] fwd(input logic [4:0] addr, input logic [WIDTH-1:0] regval);
    if (addr == 5'd0) return regval;
    if (MEM_RegWrite_i && MEM_RDAddr_i == addr) return MEM_Data_i;
    if (WB_RegWrite_i && WB_RDAddr_i == addr) return WB_Data_i;
    return regval;
  endfunction

  function automatic logic [WIDTH-1:0] alu_model(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int signed sa;
    int signed sb;
    logic [WIDTH-1:0] r;
    sa = a;
    sb = b;
    case (op)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = a + b;
      3'b110:  r = a - b;
      3'b111:  r = (sa < sb) ? 1 : 0;
      3'b011:  r = a * b;
      default: r = 0;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed, input logic [WIDTH-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_exmem(input string tag);
    checkOutput({tag, "_valid"}, WIDTH'(valid_o), WIDTH'(exp_valid));
    checkOutput({tag, "_result"}, ALUResult_o, exp_result);
    checkOutput({tag, "_store"}, StoreData_o, exp_store);
    checkOutput({tag, "_wbaddr"}, WIDTH'(WBAddr_o), WIDTH'(exp_wb));
    checkOutput({tag, "_ctrl"}, WIDTH'({MemtoReg_o, RegWrite_o, MemRead_o, MemWrite_o}), WIDTH'(exp_ctrl));
  endtask

  task automatic model_reset();
    exp_valid  = 1'b0;
    exp_result = '0;
    exp_store  = '0;
    exp_wb     = '0;
    exp_ctrl   = '0;
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic src, input logic dst,
                               input logic [3:0] ctrl, input logic [WIDTH-1:0] rs, input logic [WIDTH-1:0] rt,
                               input logic [WIDTH-1:0] imm, input logic [4:0] rsa, input logic [4:0] rta,
                               input logic [4:0] rda);
    valid_i = v;
    ALUCtrl_i = op;
    ALUSrc_i = src;
    RegDst_i = dst;
    {MemtoReg_i, RegWrite_i, MemRead_i, MemWrite_i} = ctrl;
    RS_i = rs;
    RT_i = rt;
    SignExtend_i = imm;
    RSAddr_i = rsa;
    RTAddr_i = rta;
    RDAddr_i = rda;
  endtask

  task automatic set_fwd(input logic mrw, input logic [4:0] ma, input logic [WIDTH-1:0] md,
                         input logic wrw, input logic [4:0] wa, input logic [WIDTH-1:0] wd);
    MEM_RegWrite_i = mrw;
    MEM_RDAddr_i = ma;
    MEM_Data_i = md;
    WB_RegWrite_i = wrw;
    WB_RDAddr_i = wa;
    WB_Data_i = wd;
  endtask

  // Runs the instruction currently on the inputs to completion and checks
  // EX/MEM afterwards. Called just after a rising edge.
  task automatic exec_instr(input string tag);
    logic [WIDTH-1:0] a, b, rt_f, res;
    logic [4:0] dest;
    logic [3:0] ctrl;
    logic sv_mrw, sv_wrw;
    logic [4:0] sv_ma, sv_wa;
    logic [WIDTH-1:0] sv_md, sv_wd;
    int stall_cnt;
    int guard;
    a = fwd(RSAddr_i, RS_i);
    rt_f = fwd(RTAddr_i, RT_i);
    b = ALUSrc_i ? SignExtend_i : rt_f;
    res = alu_model(ALUCtrl_i, a, b);
    dest = RegDst_i ? RDAddr_i : RTAddr_i;
    ctrl = {MemtoReg_i, RegWrite_i, MemRead_i, MemWrite_i};
    #1;
    if (valid_i && ALUCtrl_i == 3'b011) begin
      checkOutput({tag, "_stall_launch"}, WIDTH'(stall_o), 1);
      sv_mrw = MEM_RegWrite_i; sv_ma = MEM_RDAddr_i; sv_md = MEM_Data_i;
      sv_wrw = WB_RegWrite_i;  sv_wa = WB_RDAddr_i;  sv_wd = WB_Data_i;
      stall_cnt = 1;
      guard = 0;
      @(posedge clk_i); #1;
      while (stall_o === 1'b1 && guard < 4 * WIDTH) begin
        checkOutput({tag, "_busy_bubble"}, WIDTH'(valid_o), 0);
        // Forwarding traffic during the multiply must not disturb it
        set_fwd(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'($urandom_range(1, 31)), $urandom);
        stall_cnt++;
        guard++;
        @(posedge clk_i); #1;
      end
      checkOutput({tag, "_stall_cycles"}, WIDTH'(stall_cnt), WIDTH);
      checkOutput({tag, "_last_bubble"}, WIDTH'(valid_o), 0);
      set_fwd(sv_mrw, sv_ma, sv_md, sv_wrw, sv_wa, sv_wd);
      @(posedge clk_i); #1;
    end else begin
      checkOutput({tag, "_stall"}, WIDTH'(stall_o), 0);
      @(posedge clk_i); #1;
    end
    if (valid_i) begin
      exp_valid  = 1'b1;
      exp_result = res;
      exp_store  = rt_f;
      exp_wb     = dest;
      exp_ctrl   = ctrl;
    end else begin
      exp_valid = 1'b0;
      exp_ctrl  = 4'd0;
    end
    check_exmem(tag);
  endtask

  logic [2:0] op_table [8];

  initial begin
    op_table = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011, 3'b100, 3'b101};

    // Reset
    rst_i = 1'b1;
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 4'd0, '0, '0, '0, 5'd0, 5'd0, 5'd0);
    set_fwd(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    repeat (2) @(posedge clk_i);
    #1;
    model_reset();
    check_exmem("reset");
    checkOutput("reset_stall", WIDTH'(stall_o), 0);
    rst_i = 1'b0;

    // ADD 5 + 7, no hazards
    applyStimulus(1'b1, 3'b010, 1'b0, 1'b1, 4'b0100, 32'd5, 32'd7, '0, 5'd1, 5'd2, 5'd9);
    exec_instr("add");
    checkOutput("add_value", ALUResult_o, 32'd12);

    // SUB with both MEM and WB matching RS: MEM wins
    set_fwd(1'b1, 5'd3, 32'd100, 1'b1, 5'd3, 32'd50);
    applyStimulus(1'b1, 3'b110, 1'b0, 1'b1, 4'b0100, 32'd9, 32'd30, '0, 5'd3, 5'd4, 5'd10);
    exec_instr("sub_fwd");
    checkOutput("sub_fwd_value", ALUResult_o, 32'd70);

    // Same SUB with forwarding sources pointing at r0: no forwarding
    set_fwd(1'b1, 5'd0, 32'd100, 1'b1, 5'd0, 32'd50);
    applyStimulus(1'b1, 3'b110, 1'b0, 1'b1, 4'b0100, 32'd9, 32'd30, '0, 5'd0, 5'd0, 5'd10);
    exec_instr("sub_nofwd");
    checkOutput("sub_nofwd_value", ALUResult_o, 32'hFFFF_FFEB);
    set_fwd(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);

    // MUL 0xFFFFFFFF * 3, immediately followed by SLT -2 < 1
    applyStimulus(1'b1, 3'b011, 1'b0, 1'b1, 4'b0100, 32'hFFFF_FFFF, 32'd3, '0, 5'd5, 5'd6, 5'd17);
    exec_instr("mul");
    checkOutput("mul_value", ALUResult_o, 32'hFFFF_FFFD);
    applyStimulus(1'b1, 3'b111, 1'b1, 1'b1, 4'b0100, 32'hFFFF_FFFE, 32'd8, 32'd1, 5'd5, 5'd6, 5'd18);
    exec_instr("slt_after_mul");
    checkOutput("slt_value", ALUResult_o, 32'd1);

    // Reset while the multiplier counter is at 10
    applyStimulus(1'b1, 3'b011, 1'b0, 1'b1, 4'b0100, 32'd1234, 32'd5678, '0, 5'd7, 5'd8, 5'd19);
    #1;
    checkOutput("abort_stall", WIDTH'(stall_o), 1);
    repeat (11) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 4'd0, '0, '0, '0, 5'd0, 5'd0, 5'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    model_reset();
    check_exmem("abort_reset");
    checkOutput("abort_reset_stall", WIDTH'(stall_o), 0);
    for (int i = 0; i < WIDTH + 4; i++) begin
      @(posedge clk_i); #1;
      checkOutput("abort_no_result", WIDTH'(valid_o), 0);
    end
    checkOutput("abort_result_clear", ALUResult_o, 0);

    // Bubble with control asserted on the inputs
    applyStimulus(1'b0, 3'b010, 1'b0, 1'b1, 4'b0101, 32'd1, 32'd2, '0, 5'd1, 5'd2, 5'd3);
    exec_instr("bubble");

    // Random instructions against the model
    for (int n = 0; n < 60; n++) begin
      set_fwd(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
              1'($urandom), 5'($urandom_range(0, 3)), $urandom);
      applyStimulus(($urandom_range(0, 99) < 85), op_table[$urandom_range(0, 7)],
                    1'($urandom), 1'($urandom), 4'($urandom), $urandom, $urandom, $urandom,
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom));
      exec_instr("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
